// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges ID load-use stalls, multi-cycle EX ops and exception flushes.
// Optional PIPE_CTRL_PERF_EN adds a saturating stall_cycles_o counter of cycles with any stall asserted.
module pipe_ctrl #(
    parameter int MC_LEN_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id_i,
    input  logic                ex_mc_start_i,
    input  logic [MC_LEN_W-1:0] ex_mc_len_i,
    input  logic                excp_i,
    input  logic [31:0]         excp_vec_i,
    output logic [5:0]          stall_o,
    output logic                flush_o,
    output logic [31:0]         new_pc_o,
    output logic                ex_mc_done_o,
    output logic                busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]         stall_cycles_o
`endif
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_MCYC  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    logic [1:0]          state, state_nxt;
    logic [MC_LEN_W-1:0] cnt, cnt_nxt;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        stall_o      = '0;
        ex_mc_done_o = 1'b0;
        busy_o       = 1'b0;
        case (state)
            S_RUN: begin
                if (excp_i) begin
                    state_nxt = S_FLUSH;
                end else if (ex_mc_start_i && (ex_mc_len_i != '0)) begin
                    stall_o = STALL_EX;
                    if (ex_mc_len_i == MC_LEN_W'(1)) begin
                        ex_mc_done_o = 1'b1;
                    end else begin
                        cnt_nxt   = ex_mc_len_i - MC_LEN_W'(1);
                        state_nxt = S_MCYC;
                    end
                end else if (stallreq_id_i) begin
                    stall_o = STALL_ID;
                end
            end
            S_MCYC: begin
                busy_o = 1'b1;
                // An exception aborts the op outright: no done pulse, counter cleared.
                if (excp_i) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = '0;
                end else begin
                    stall_o = STALL_EX;
                    cnt_nxt = cnt - MC_LEN_W'(1);
                    if (cnt == MC_LEN_W'(1)) begin
                        ex_mc_done_o = 1'b1;
                        state_nxt    = S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                busy_o    = 1'b1;
                state_nxt = S_RUN;
            end
            default: begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end
        endcase
        if (rst) begin
            stall_o      = '0;
            ex_mc_done_o = 1'b0;
            busy_o       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            cnt      <= '0;
            flush_o  <= 1'b0;
            new_pc_o <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            flush_o <= (state_nxt == S_FLUSH);
            // Only a RUN/MCYC exception reaches FLUSH, so a second one during FLUSH never overwrites.
            if (state_nxt == S_FLUSH) begin
                new_pc_o <= excp_vec_i;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if ((stall_o != '0) && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = perf_cnt;
`endif

endmodule
